// File: rtl/store_checker.sv
// Watches core stores and latches a sticky pass/fail verdict for a test run.
// Optional watchdog enabled by defining STORE_CHECKER_TIMEOUT_EN.
module store_checker #(
    parameter logic [31:0] PASS_ADDR      = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd7,
    parameter logic [31:0] IGNORE_ADDR    = 32'd96,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             done,
    output logic [CNT_W-1:0] store_count,
    output logic [31:0]      fail_addr,
    output logic [31:0]      fail_data
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("store_checker: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef STORE_CHECKER_TIMEOUT_EN
    typedef enum logic [2:0] {ST_IDLE, ST_ARMED, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cyc, cyc_nxt;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PASS, ST_FAIL} state_t;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]      fa_nxt, fd_nxt;
    logic             hit_pass, judged;

    assign hit_pass = (DataAdr == PASS_ADDR) && (WriteData == PASS_DATA);
    assign judged   = (DataAdr == PASS_ADDR) || (DataAdr != IGNORE_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            store_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
`ifdef STORE_CHECKER_TIMEOUT_EN
            cyc         <= '0;
`endif
        end else begin
            state       <= state_nxt;
            store_count <= cnt_nxt;
            fail_addr   <= fa_nxt;
            fail_data   <= fd_nxt;
`ifdef STORE_CHECKER_TIMEOUT_EN
            cyc         <= cyc_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = store_count;
        fa_nxt    = fail_addr;
        fd_nxt    = fail_data;
`ifdef STORE_CHECKER_TIMEOUT_EN
        cyc_nxt   = cyc;
`endif
        case (state)
            ST_ARMED: begin
`ifdef STORE_CHECKER_TIMEOUT_EN
                cyc_nxt = cyc + CNT_W'(1);
`endif
                if (MemWrite) begin
                    if (store_count != '1) cnt_nxt = store_count + CNT_W'(1);
                    if (hit_pass) begin
                        state_nxt = ST_PASS;
                    end else if (judged) begin
                        state_nxt = ST_FAIL;
                        fa_nxt    = DataAdr;
                        fd_nxt    = WriteData;
                    end
                end
`ifdef STORE_CHECKER_TIMEOUT_EN
                // a verdict store on the last allowed cycle wins over the watchdog
                if (state_nxt == ST_ARMED && cyc == TO_LAST) state_nxt = ST_TIMEOUT;
`endif
            end
            default: begin
                // IDLE and terminal states: stores are dropped, start re-arms
                if (start) begin
                    state_nxt = ST_ARMED;
                    cnt_nxt   = '0;
                    fa_nxt    = '0;
                    fd_nxt    = '0;
`ifdef STORE_CHECKER_TIMEOUT_EN
                    cyc_nxt   = '0;
`endif
                end
            end
        endcase
    end

    assign busy = (state == ST_ARMED);
    assign pass = (state == ST_PASS);
    assign fail = (state == ST_FAIL);
`ifdef STORE_CHECKER_TIMEOUT_EN
    assign timeout = (state == ST_TIMEOUT);
`else
    assign timeout = 1'b0;
`endif
    assign done = pass | fail | timeout;

endmodule

// File: tb/tb_store_checker.sv
// Self-checking bench for store_checker: vector table, corner sequences, random run vs model.
module tb_store_checker;
    localparam int CNT_W = 4;
    localparam int TO    = 10;
    localparam logic [31:0] P_ADDR = 32'd100;
    localparam logic [31:0] P_DATA = 32'd7;
    localparam logic [31:0] I_ADDR = 32'd96;
`ifdef STORE_CHECKER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, MemWrite = 1'b0;
    logic [31:0] DataAdr = '0, WriteData = '0;
    logic busy, pass, fail, timeout, done;
    logic [CNT_W-1:0] store_count;
    logic [31:0] fail_addr, fail_data;

    store_checker #(
        .PASS_ADDR(P_ADDR), .PASS_DATA(P_DATA), .IGNORE_ADDR(I_ADDR),
        .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData), .busy(busy), .pass(pass),
        .fail(fail), .timeout(timeout), .done(done), .store_count(store_count),
        .fail_addr(fail_addr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference model: 0 idle, 1 armed, 2 pass, 3 fail, 4 timeout
    int          m_st, m_cnt, m_cyc;
    logic [31:0] m_fa, m_fd;

    function automatic void model_reset();
        m_st = 0; m_cnt = 0; m_cyc = 0; m_fa = 0; m_fd = 0;
    endfunction

    function automatic void model_step(input bit st, input bit mw, input logic [31:0] a,
                                       input logic [31:0] d);
        if (m_st == 1) begin
            if (mw) begin
                if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
                if (a == P_ADDR && d == P_DATA) m_st = 2;
                else if (a != I_ADDR) begin m_st = 3; m_fa = a; m_fd = d; end
            end
            if (TO_EN && m_st == 1 && m_cyc == TO - 1) m_st = 4;
            m_cyc = m_cyc + 1;
        end else if (st) begin
            m_st = 1; m_cnt = 0; m_cyc = 0; m_fa = 0; m_fd = 0;
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".busy"},      busy,        32'(m_st == 1));
        chk({tag, ".pass"},      pass,        32'(m_st == 2));
        chk({tag, ".fail"},      fail,        32'(m_st == 3));
        chk({tag, ".timeout"},   timeout,     32'(m_st == 4));
        chk({tag, ".done"},      done,        32'(m_st >= 2));
        chk({tag, ".count"},     store_count, 32'(m_cnt));
        chk({tag, ".fail_addr"}, fail_addr,   m_fa);
        chk({tag, ".fail_data"}, fail_data,   m_fd);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".pass"}, pass, 0);
        chk({tag, ".fail"}, fail, 0);
        chk({tag, ".timeout"}, timeout, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".count"}, store_count, 0);
        chk({tag, ".fail_addr"}, fail_addr, 0);
        chk({tag, ".fail_data"}, fail_data, 0);
    endtask

    // apply inputs, clock once, advance model, sample 1 time unit after the edge
    task automatic cycle(input bit st, input bit mw, input logic [31:0] a, input logic [31:0] d);
        start = st; MemWrite = mw; DataAdr = a; WriteData = d;
        @(posedge clk);
        model_step(st, mw, a, d);
        #1;
    endtask

    task automatic async_reset_pulse(input string tag);
        #3 reset = 1'b0;
        #1 check_zero(tag);
        model_reset();
        #2 reset = 1'b1;
    endtask

    typedef struct {
        bit          st, mw;
        logic [31:0] a, d;
        bit          busy, pass, fail;
        int          cnt;
        logic [31:0] fa, fd;
    } vec_t;
    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 0,   0, 0, 1, 0, 0, 0,   0, 0};  // arm
        tbl[1]  = '{0, 1,  96, 5, 1, 0, 0, 1,   0, 0};  // ignored addr counted
        tbl[2]  = '{0, 1, 100, 7, 0, 1, 0, 2,   0, 0};  // pass
        tbl[3]  = '{1, 1, 104, 1, 1, 0, 0, 0,   0, 0};  // re-arm, store dropped
        tbl[4]  = '{0, 1, 100, 8, 0, 0, 1, 1, 100, 8};  // pass addr, wrong data
        tbl[5]  = '{1, 0,   0, 0, 1, 0, 0, 0,   0, 0};  // re-arm clears capture
        tbl[6]  = '{0, 1, 104, 3, 0, 0, 1, 1, 104, 3};  // bad addr
        tbl[7]  = '{0, 1, 100, 7, 0, 0, 1, 1, 104, 3};  // terminal: no change
        tbl[8]  = '{1, 0,   0, 0, 1, 0, 0, 0,   0, 0};  // re-arm
        tbl[9]  = '{1, 1,  96, 9, 1, 0, 0, 1,   0, 0};  // start in ARMED ignored
        tbl[10] = '{0, 0,   0, 0, 1, 0, 0, 1,   0, 0};  // idle armed cycle

        reset = 1'b0;
        #22;
        check_zero("por");
        model_reset();
        reset = 1'b1;

        // store in IDLE is ignored
        cycle(0, 1, 104, 3);
        check_model("idle_store");

        foreach (tbl[i]) begin
            cycle(tbl[i].st, tbl[i].mw, tbl[i].a, tbl[i].d);
            chk($sformatf("vec%0d.busy", i), busy, 32'(tbl[i].busy));
            chk($sformatf("vec%0d.pass", i), pass, 32'(tbl[i].pass));
            chk($sformatf("vec%0d.fail", i), fail, 32'(tbl[i].fail));
            chk($sformatf("vec%0d.timeout", i), timeout, 0);
            chk($sformatf("vec%0d.count", i), store_count, 32'(tbl[i].cnt));
            chk($sformatf("vec%0d.fail_addr", i), fail_addr, tbl[i].fa);
            chk($sformatf("vec%0d.fail_data", i), fail_data, tbl[i].fd);
        end

        // reset in the middle of a run discards it
        for (int i = 0; i < 3; i++) cycle(0, 1, 96, 1);
        check_model("pre_reset");
        async_reset_pulse("mid_reset");
        cycle(1, 0, 0, 0);
        cycle(0, 1, 100, 7);
        chk("rearm.pass", pass, 1);
        chk("rearm.count", store_count, 1);
        chk("rearm.fail", fail, 0);

`ifdef STORE_CHECKER_TIMEOUT_EN
        cycle(1, 0, 0, 0);
        for (int i = 1; i < TO; i++) begin
            cycle(0, 0, 0, 0);
            chk($sformatf("to_wait%0d.timeout", i), timeout, 0);
            chk($sformatf("to_wait%0d.busy", i), busy, 1);
        end
        cycle(0, 0, 0, 0);
        chk("to.timeout", timeout, 1);
        chk("to.busy", busy, 0);
        chk("to.done", done, 1);
        cycle(1, 0, 0, 0);
        chk("to_rearm.timeout", timeout, 0);
        for (int i = 1; i < TO; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 100, 7);
        chk("to_prio.pass", pass, 1);
        chk("to_prio.timeout", timeout, 0);
`else
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, 96, i);
        chk("sat.count", store_count, 15);
        chk("sat.busy", busy, 1);
        cycle(0, 1, 100, 7);
        chk("sat_pass.count", store_count, 15);
        chk("sat_pass.pass", pass, 1);
        chk("sat_pass.timeout", timeout, 0);
`endif
        check_model("seq_end");

        // randomized run against the model
        async_reset_pulse("rand_reset");
        for (int n = 0; n < 1500; n++) begin
            bit          st, mw;
            logic [31:0] a, d;
            int          sel;
            if ($urandom_range(0, 299) == 0) begin
                async_reset_pulse($sformatf("rand%0d.reset", n));
            end
            st  = ($urandom_range(0, 7) == 0);
            mw  = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 5);
            a   = (sel < 3) ? I_ADDR : (sel == 3) ? P_ADDR : (sel == 4) ? 32'd104 : $urandom;
            d   = $urandom_range(0, 1) ? P_DATA : 32'($urandom_range(0, 15));
            cycle(st, mw, a, d);
            check_model($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
